// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single data memory: processor port (p0) and
// loader/debug port (p1), with registered grants and bounded bursts per owner.
module mem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [WIDTH-1:0]  p0_addr,
    input  logic [WIDTH-1:0]  p1_addr,
    input  logic [WIDTH-1:0]  p0_wdata,
    input  logic [WIDTH-1:0]  p1_wdata,
    input  logic [2:0]        p0_len,
    input  logic [2:0]        p1_len,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_stall,
    output logic              p1_stall,
    output logic [WIDTH-1:0]  p0_rdata,
    output logic [WIDTH-1:0]  p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_in,
    output logic [2:0]        mem_len,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [WIDTH-1:0]  mem_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [2:0] BMAX3 = 3'(BURST_MAX);
    localparam logic [3:0] BMAX4 = 4'(BURST_MAX);

    state_t     state_r;
    state_t     state_s;
    logic [2:0] beat_r;
    logic [2:0] beat_s;
    logic       last_owner_r;
    logic       last_owner_s;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       access0_s;
    logic       access1_s;
    logic       burst_done_s;

    // Upper address bits are not forwarded to the memory.
    logic unused_addr_s;
    assign unused_addr_s = ^{p0_addr[WIDTH-1:ADDR_W], p1_addr[WIDTH-1:ADDR_W]};

    assign access0_s = gnt0_r & p0_req;
    assign access1_s = gnt1_r & p1_req;
    // True when the beat being performed this cycle (or an earlier one) fills the burst.
    assign burst_done_s = (({1'b0, beat_r} + 4'd1) >= BMAX4);

    // Next-state, burst counter and last-owner computation.
    always_comb begin
        state_s      = state_r;
        beat_s       = beat_r;
        last_owner_s = last_owner_r;
        case (state_r)
            IDLE: begin
                if (p0_req && p1_req) begin
                    state_s = last_owner_r ? OWN0 : OWN1;
                end else if (p0_req) begin
                    state_s = OWN0;
                end else if (p1_req) begin
                    state_s = OWN1;
                end else begin
                    state_s = IDLE;
                end
            end
            OWN0: begin
                if (!p0_req) begin
                    state_s = p1_req ? OWN1 : IDLE;
                end else if (burst_done_s && p1_req) begin
                    state_s = OWN1;
                end else begin
                    state_s = OWN0;
                end
            end
            OWN1: begin
                if (!p1_req) begin
                    state_s = p0_req ? OWN0 : IDLE;
                end else if (burst_done_s && p0_req) begin
                    state_s = OWN0;
                end else begin
                    state_s = OWN1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (state_s != state_r) begin
            beat_s = 3'd0;
        end else if ((access0_s || access1_s) && (beat_r < BMAX3)) begin
            beat_s = beat_r + 3'd1;
        end else begin
            beat_s = beat_r;
        end

        case (state_s)
            OWN0:    last_owner_s = 1'b0;
            OWN1:    last_owner_s = 1'b1;
            default: last_owner_s = last_owner_r;
        endcase
    end

    // State and grant registers; grants mirror the registered state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= IDLE;
            beat_r       <= 3'd0;
            last_owner_r <= 1'b1;
            gnt0_r       <= 1'b0;
            gnt1_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            beat_r       <= beat_s;
            last_owner_r <= last_owner_s;
            gnt0_r       <= (state_s == OWN0);
            gnt1_r       <= (state_s == OWN1);
        end
    end

    assign p0_gnt   = gnt0_r;
    assign p1_gnt   = gnt1_r;
    assign p0_stall = p0_req & ~gnt0_r;
    assign p1_stall = p1_req & ~gnt1_r;

    // Memory-side mux: everything idles at zero when no access is in progress.
    always_comb begin
        mem_addr  = '0;
        mem_in    = '0;
        mem_len   = 3'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        if (access0_s) begin
            mem_addr  = p0_addr[ADDR_W-1:0];
            mem_in    = p0_wdata;
            mem_len   = p0_len;
            mem_read  = ~p0_we;
            mem_write = p0_we;
            p0_rdata  = p0_we ? '0 : mem_out;
        end else if (access1_s) begin
            mem_addr  = p1_addr[ADDR_W-1:0];
            mem_in    = p1_wdata;
            mem_len   = p1_len;
            mem_read  = ~p1_we;
            mem_write = p1_we;
            p1_rdata  = p1_we ? '0 : mem_out;
        end else begin
            mem_addr  = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant latency, fairness, burst limit,
// handover and asynchronous reset during a write burst.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [2:0]  p0_len, p1_len;
    logic        p0_gnt, p1_gnt, p0_stall, p1_stall;
    logic [31:0] p0_rdata, p1_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_in;
    logic [2:0]  mem_len;
    logic        mem_read, mem_write;
    logic [31:0] mem_out;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.WIDTH(32), .ADDR_W(8), .BURST_MAX(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_len(p0_len), .p1_len(p1_len),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_stall(p0_stall), .p1_stall(p1_stall),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_len(mem_len),
        .mem_read(mem_read), .mem_write(mem_write), .mem_out(mem_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
        p0_addr = 32'h0; p1_addr = 32'h0; p0_wdata = 32'h0; p1_wdata = 32'h0;
        p0_len = 3'd0; p1_len = 3'd0; mem_out = 32'h1234_5678;

        // Reset state
        #12;
        chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        chk("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        RST_N = 1'b1;
        tick();

        // Single read by p0 from IDLE
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'hFFFF_FF10; p0_len = 3'd5;
        #1;
        chk("rd_req_stall", {31'd0, p0_stall}, 32'd1);
        chk("rd_req_gnt", {31'd0, p0_gnt}, 32'd0);
        chk("rd_req_memrd", {31'd0, mem_read}, 32'd0);
        tick();
        chk("rd_gnt", {31'd0, p0_gnt}, 32'd1);
        chk("rd_stall", {31'd0, p0_stall}, 32'd0);
        chk("rd_memrd", {31'd0, mem_read}, 32'd1);
        chk("rd_addr", {24'd0, mem_addr}, 32'h10);
        chk("rd_len", {29'd0, mem_len}, 32'd5);
        chk("rd_rdata", p0_rdata, 32'h1234_5678);
        chk("rd_p1_rdata", p1_rdata, 32'h0);
        p0_req = 1'b0;
        tick();
        chk("rd_idle_gnt", {31'd0, p0_gnt}, 32'd0);
        chk("rd_idle_memrd", {31'd0, mem_read}, 32'd0);
        chk("rd_idle_addr", {24'd0, mem_addr}, 32'h0);
        chk("rd_idle_len", {29'd0, mem_len}, 32'd0);

        // Both request right after reset: p0 first, 4-beat burst, then p1
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
        tick();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h4; p0_len = 3'd2;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h30; p1_wdata = 32'h55; p1_len = 3'd1;
        #1;
        chk("both_c1_p0_stall", {31'd0, p0_stall}, 32'd1);
        chk("both_c1_p1_stall", {31'd0, p1_stall}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("both_p0_gnt", {31'd0, p0_gnt}, 32'd1);
            chk("both_p1_stall", {31'd0, p1_stall}, 32'd1);
            chk("both_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        end
        tick();
        chk("both_c6_p1_gnt", {31'd0, p1_gnt}, 32'd1);
        chk("both_c6_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        chk("both_c6_p0_stall", {31'd0, p0_stall}, 32'd1);
        chk("both_c6_memwr", {31'd0, mem_write}, 32'd1);
        chk("both_c6_memin", mem_in, 32'h55);
        chk("both_c6_addr", {24'd0, mem_addr}, 32'h30);
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
        chk("both_idle_p1_gnt", {31'd0, p1_gnt}, 32'd0);

        // p1 sole writer for 10 cycles: ownership persists past BURST_MAX
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("wr_p1_gnt", {31'd0, p1_gnt}, 32'd1);
            chk("wr_memwr", {31'd0, mem_write}, 32'd1);
            chk("wr_memin", mem_in, 32'hDEAD_BEEF);
            tick();
        end
        chk("wr_addr", {24'd0, mem_addr}, 32'h20);
        chk("wr_memrd", {31'd0, mem_read}, 32'd0);

        // p0 arrives while p1 is saturated: immediate handover
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h44; mem_out = 32'hA0B0_C0D0;
        #1;
        chk("ho_p0_stall", {31'd0, p0_stall}, 32'd1);
        tick();
        chk("ho_p0_gnt", {31'd0, p0_gnt}, 32'd1);
        chk("ho_p1_stall", {31'd0, p1_stall}, 32'd1);
        chk("ho_addr", {24'd0, mem_addr}, 32'h44);
        chk("ho_p0_rdata", p0_rdata, 32'hA0B0_C0D0);

        // p0 drops while p1 waits: OWN1 next cycle, no bubble
        p0_req = 1'b0; p1_addr = 32'h8; p1_wdata = 32'h0000_A5A5;
        tick();
        chk("drop_p1_gnt", {31'd0, p1_gnt}, 32'd1);
        chk("drop_p0_rdata", p0_rdata, 32'h0);
        chk("drop_memwr", {31'd0, mem_write}, 32'd1);
        chk("drop_memin", mem_in, 32'h0000_A5A5);
        p1_we = 1'b0;
        #1;
        chk("drop_rd_memwr", {31'd0, mem_write}, 32'd0);
        chk("drop_rd_memrd", {31'd0, mem_read}, 32'd1);
        chk("drop_p1_rdata", p1_rdata, 32'hA0B0_C0D0);
        chk("drop_rd_p0_rdata", p0_rdata, 32'h0);
        p1_req = 1'b0;
        tick();

        // Reset in the middle of a p0 write burst
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'hC; p0_wdata = 32'h11;
        tick();
        chk("rb_memwr1", {31'd0, mem_write}, 32'd1);
        tick();
        chk("rb_memwr2", {31'd0, mem_write}, 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("rb_async_memwr", {31'd0, mem_write}, 32'd0);
        chk("rb_async_gnt", {31'd0, p0_gnt}, 32'd0);
        chk("rb_async_stall", {31'd0, p0_stall}, 32'd1);
        tick();
        chk("rb_held_memwr", {31'd0, mem_write}, 32'd0);
        RST_N = 1'b1;
        #2;
        chk("rb_rel_gnt", {31'd0, p0_gnt}, 32'd0);
        tick();
        chk("rb_regnt", {31'd0, p0_gnt}, 32'd1);
        chk("rb_rewr", {31'd0, mem_write}, 32'd1);
        p0_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width of each requester port.
REQ-002 SHALL have parameter ADDR_W, default 8, memory address bits forwarded to the data memory.
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum consecutive granted accesses per owner while the other port waits.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: ports CLK (input, 1) and RST_N (input, 1), listed first.
REQ-005 SHALL have p0_req, p1_req  input  1  access request (p0 = processor MEM stage, p1 = loader/debug).
REQ-006 SHALL have p0_we, p1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have p0_addr, p1_addr  input  WIDTH  byte address; only [ADDR_W-1:0] forwarded.
REQ-008 SHALL have p0_wdata, p1_wdata  input  WIDTH  write data.
REQ-009 SHALL have p0_len, p1_len  input  3  access length code, passed through unchanged.
REQ-010 SHALL have p0_gnt, p1_gnt  output  1  registered grant.
REQ-011 SHALL have p0_stall, p1_stall  output  1  request pending without grant.
REQ-012 SHALL have p0_rdata, p1_rdata  output  WIDTH  read data.
REQ-013 SHALL have mem_addr (ADDR_W), mem_in (WIDTH), mem_len (3), mem_read (1), mem_write (1) outputs, and mem_out (WIDTH) input, to the data memory.

Function
REQ-014 SHALL implement states IDLE, OWN0, OWN1; p0_gnt = (state==OWN0), p1_gnt = (state==OWN1).
REQ-015 IDLE: a request sampled at edge t SHALL yield grant from cycle t+1 (one-cycle grant latency); no request keeps IDLE.
REQ-016 IDLE with both requests SHALL grant the port not served most recently (last_owner); after reset last_owner = 1, so p0 wins first.
REQ-017 An access SHALL occur in every cycle where gnt && req of the same port; that cycle counts as one beat.
REQ-018 During an access, mem_addr/mem_in/mem_len SHALL equal the owner's addr[ADDR_W-1:0]/wdata/len, mem_write = owner we, mem_read = ~owner we.
REQ-019 With no access in a cycle, mem_read and mem_write SHALL be 0 and mem_addr, mem_in, mem_len 0.
REQ-020 Owner's rdata SHALL equal mem_out combinationally during a read access; the other port's rdata SHALL be 0.
REQ-021 pX_stall SHALL equal pX_req && !pX_gnt, combinationally.
REQ-022 A 3-bit beat counter SHALL reset to 0 on entering OWNx and increment per access, saturating at BURST_MAX.
REQ-023 Owner drops req: next state SHALL be OWN(other) if other req high, else IDLE.
REQ-024 Owner holds req, counter reaches BURST_MAX, other req high: next state SHALL be OWN(other), counter cleared.
REQ-025 Owner holds req, other idle: ownership SHALL continue indefinitely (counter saturated, no re-arbitration).
REQ-026 last_owner SHALL update on every transition into OWN0/OWN1.
REQ-027 Direct OWN0<->OWN1 handover SHALL take effect the next cycle with no IDLE bubble.

Reset
REQ-028 RST_N low SHALL asynchronously force state IDLE, counter 0, last_owner 1, both grants 0, mem_write 0, mem_read 0.
REQ-029 Reset mid-burst SHALL abort the in-flight access with no write issued after RST_N falls.
REQ-030 After RST_N rises, first grant SHALL appear no earlier than one edge after a sampled request.

Verification
REQ-031 p0_req=1 we=0 addr=0x10 from IDLE -> p0_gnt=1 next cycle, mem_read=1, mem_addr=0x10, p0_rdata=mem_out, p0_stall=1 only in the request cycle.
REQ-032 Both req=1 immediately after reset -> p0 granted first; p1_stall=1 for 4 beats (BURST_MAX=4); p1_gnt=1 on cycle 6, no IDLE gap.
REQ-033 p1 sole requester writing 0xDEADBEEF to 0x20 for 10 cycles -> p1_gnt held all 10, mem_write=1, mem_in=0xDEADBEEF every cycle.
REQ-034 p0 owner drops req while p1_req=1 -> OWN1 next cycle; p0_rdata=0 and mem_write follows p1_we.
REQ-035 RST_N pulled low mid-write burst by p0 -> mem_write, p0_gnt 0 immediately (before next edge); after release, p0 re-granted one edge after request.
